lsu_dmem_port: RTL and testbench
================================

# lsu_dmem_port

Load/store unit that sits between the DT1 execute stage and the data memory and acts as the requester for the memory's write-enable encoding (00 none, 01 word, 10 half, 11 byte; combinational read, write on clock edge). It accepts one load or store per valid/ready handshake and drives address, write data and write enable. For loads, it extracts and sign- or zero-extends the addressed lanes. Misaligned half/word accesses are handled in hardware: loads become two aligned word reads, stores become a sequence of byte writes.

## Interface
- No parameters; data/address width fixed at 32.
- clk  in  1  rising-edge clock
- resetn  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle, request accepted when req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  qualifies rsp_valid; set for req_size = 11
- dmem_we  out  2  memory write enable, same encoding as memory
- dmem_a  out  32  memory byte address
- dmem_wd  out  32  memory write data
- dmem_rd  in  32  memory read data, valid combinationally for dmem_a

## Operation
- States: IDLE, ACC1, ACC2 (misaligned load second word), BYTES (misaligned store), RESP.
- IDLE: req_ready = 1. On handshake, the unit registers the request, clears the byte counter and classifies the request:
  - A request is aligned when it is a byte access, a half with addr[0] = 0, or a word with addr[1:0] = 00.
  - size 11 -> RESP with error.
  - misaligned store -> BYTES.
  - all others -> ACC1.
- ACC1, aligned store: dmem_a = addr, dmem_wd = wdata, dmem_we = 11/10/01 for byte/half/word. Memory selects the lane from dmem_a. Next state RESP.
- ACC1, load: dmem_a = {addr[31:2],00}, dmem_we = 00, and dmem_rd is latched as the low word.
  - If the load is aligned, the unit extracts the lane and goes to RESP.
  - Byte lane = addr[1:0].
  - Half lane = addr[1].
  - If the load is misaligned, the next state is ACC2.
- ACC2: dmem_a = {addr[31:2],00} + 4, modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000. dmem_rd is latched as the high word.
  - Result = ({high,low} >> 8*addr[1:0]) truncated to the access size, then extended.
  - Next state RESP.
- BYTES: byte i (i = 0..N-1, where N = 2 for half and 4 for word) is written with dmem_we = 11, dmem_a = addr + i (mod 2^32), dmem_wd = {24'b0, wdata[8i+7:8i]}.
  - Next state RESP after byte N-1.
- RESP: rsp_valid = 1, rsp_rdata = result (0 for stores/errors), rsp_err as classified. Next state IDLE.
- Extension: signed byte/half replicates bit 7/15 into the upper bits; unsigned zero-fills. Words are passed through unchanged.
- Outside ACC1/ACC2/BYTES: dmem_we = 00, dmem_a = 0, dmem_wd = 0.

## Timing
- Handshake at edge T -> first memory cycle T+1.
  - Aligned access: rsp_valid during cycle T+2.
  - Misaligned load: rsp_valid at T+3.
  - Misaligned half store: rsp_valid at T+3.
  - Misaligned word store: rsp_valid at T+5.
  - Error: rsp_valid at T+1, with no memory cycle.
- A store byte is committed at the rising edge that ends its memory cycle.
- Back-to-back: req_ready reasserts in the cycle after RESP. Minimum 3-cycle spacing between aligned requests.
- Request fields are don't-care after acceptance; the unit uses only its registered copy.
- Reset values (resetn low at an edge): state IDLE, req_ready 0 while resetn low, then 1. rsp_valid 0, rsp_rdata 0, rsp_err 0, dmem_a 0, dmem_wd 0.
- dmem_we is combinationally forced to 00 whenever resetn = 0, so no memory write occurs on a reset edge.
- Reset mid-operation: the operation is abandoned and no rsp_valid is produced. Bytes already committed by a misaligned store stay written; no further bytes are written.

## Test plan
- Aligned word store 0xDEADBEEF @0x10, then signed byte load @0x13 -> rsp_rdata 0xFFFFFFDE. Unsigned half load @0x12 -> 0x0000DEAD. Each response arrives 2 cycles after acceptance.
- Half store 0x1234 @0x22 over word 0 -> memory word @0x20 = 0x12340000. Byte store 0xAB @0x21 -> 0x1234AB00. dmem_we is 10 then 11.
- Misaligned word store 0x11223344 @0x05 -> four consecutive byte writes at 0x05..0x08. Words @0x04 = 0x223344xx, @0x08 = 0xxxxxxx11. rsp_valid at T+5. Follow-up misaligned word load @0x05 -> 0x11223344 at T+3.
- Misaligned signed half load @0x07 with word @0x04 = 0x80000000 and word @0x08 = 0x000000FF -> dmem_a 0x04 then 0x08, rsp_rdata 0xFFFFFF80.
- req_size 11 -> rsp_valid and rsp_err at T+1, rsp_rdata 0, dmem_we stays 00.
- resetn low during byte 2 of a misaligned word store -> only bytes 0-1 written, dmem_we 00 on the reset edge, no rsp_valid. req_ready = 1 in the first cycle after resetn returns high.

Source files
------------

// File: rtl/lsu_dmem_port.sv
// Load/store unit between the execute stage and a combinational-read data memory.
// Misaligned loads use two aligned word reads; misaligned stores become byte writes.
module lsu_dmem_port (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dmem_we,
  output logic [31:0] dmem_a,
  output logic [31:0] dmem_wd,
  input  logic [31:0] dmem_rd
);

  typedef enum logic [2:0] {IDLE, ACC1, ACC2, BYTES, RESP} state_t;

  state_t      state_reg, state_next;
  logic        we_reg;
  logic [1:0]  size_reg;
  logic        unsigned_reg;
  logic        aligned_reg;
  logic        err_reg;
  logic [1:0]  cnt_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] low_reg;
  logic [31:0] result_reg;

  logic [63:0] pair;
  logic [31:0] shifted;
  logic [31:0] extended;
  logic [7:0]  wbyte;
  logic        last_byte;

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 1'b1;
      2'b01:   return ~a[0];
      2'b10:   return (a == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  // Aligned loads see only the low word; the shift then selects the lane directly.
  always_comb begin
    pair     = (state_reg == ACC2) ? {dmem_rd, low_reg} : {32'd0, dmem_rd};
    shifted  = 32'(pair >> {addr_reg[1:0], 3'b000});
    extended = shifted;
    case (size_reg)
      2'b00:   extended = unsigned_reg ? {24'd0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   extended = unsigned_reg ? {16'd0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
      default: extended = shifted;
    endcase
  end

  assign wbyte     = 8'(wdata_reg >> {cnt_reg, 3'b000});
  assign last_byte = (cnt_reg == ((size_reg == 2'b01) ? 2'd1 : 2'd3));

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_rdata  = 32'd0;
    rsp_err    = 1'b0;
    dmem_we    = 2'b00;
    dmem_a     = 32'd0;
    dmem_wd    = 32'd0;
    case (state_reg)
      IDLE: begin
        req_ready = resetn;
        if (req_valid) begin
          if (req_size == 2'b11)
            state_next = RESP;
          else if (req_we && !is_aligned(req_size, req_addr[1:0]))
            state_next = BYTES;
          else
            state_next = ACC1;
        end
      end
      ACC1: begin
        if (we_reg) begin
          dmem_a     = addr_reg;
          dmem_wd    = wdata_reg;
          dmem_we    = ~size_reg;
          state_next = RESP;
        end else begin
          dmem_a     = {addr_reg[31:2], 2'b00};
          state_next = aligned_reg ? RESP : ACC2;
        end
      end
      ACC2: begin
        dmem_a     = {addr_reg[31:2], 2'b00} + 32'd4;
        state_next = RESP;
      end
      BYTES: begin
        dmem_we    = 2'b11;
        dmem_a     = addr_reg + {30'd0, cnt_reg};
        dmem_wd    = {24'd0, wbyte};
        if (last_byte)
          state_next = RESP;
      end
      RESP: begin
        rsp_valid  = 1'b1;
        rsp_rdata  = result_reg;
        rsp_err    = err_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // No memory write may land on a reset edge.
    if (!resetn)
      dmem_we = 2'b00;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      we_reg       <= 1'b0;
      size_reg     <= 2'b00;
      unsigned_reg <= 1'b0;
      aligned_reg  <= 1'b0;
      err_reg      <= 1'b0;
      cnt_reg      <= 2'd0;
      addr_reg     <= 32'd0;
      wdata_reg    <= 32'd0;
      low_reg      <= 32'd0;
      result_reg   <= 32'd0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            we_reg       <= req_we;
            size_reg     <= req_size;
            unsigned_reg <= req_unsigned;
            aligned_reg  <= is_aligned(req_size, req_addr[1:0]);
            err_reg      <= (req_size == 2'b11);
            cnt_reg      <= 2'd0;
            addr_reg     <= req_addr;
            wdata_reg    <= req_wdata;
            result_reg   <= 32'd0;
          end
        end
        ACC1: begin
          if (!we_reg) begin
            low_reg <= dmem_rd;
            if (aligned_reg)
              result_reg <= extended;
          end
        end
        ACC2:    result_reg <= extended;
        BYTES:   cnt_reg <= cnt_reg + 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dmem_port.sv
// Scoreboard bench for lsu_dmem_port: byte-array reference model, word-wide memory model,
// directed scenarios followed by randomized traffic.
module tb_lsu_dmem_port;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  dmem_we;
  logic [31:0] dmem_a;
  logic [31:0] dmem_wd;
  logic [31:0] dmem_rd;

  always #5 clk = ~clk;

  lsu_dmem_port dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .dmem_we(dmem_we), .dmem_a(dmem_a), .dmem_wd(dmem_wd),
    .dmem_rd(dmem_rd)
  );

  // Memory model: 64 words, aliased on address bits [7:2].
  logic [31:0] mem [64];
  logic [31:0] init_val [64];
  bit          mem_loaded = 1'b0;
  logic [7:0]  ref_mem [256];

  typedef struct { logic [1:0] we; logic [31:0] a; logic [31:0] wd; } wr_t;
  wr_t wlog[$];

  assign dmem_rd = mem[dmem_a[7:2]];

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int w = 0; w < 64; w++) mem[w] <= init_val[w];
      mem_loaded <= 1'b1;
    end else if (dmem_we != 2'b00) begin
      wlog.push_back('{dmem_we, dmem_a, dmem_wd});
      case (dmem_we)
        2'b01: mem[dmem_a[7:2]] <= dmem_wd;
        2'b10: mem[dmem_a[7:2]][16*dmem_a[1] +: 16] <= dmem_wd[15:0];
        default: mem[dmem_a[7:2]][8*dmem_a[1:0] +: 8] <= dmem_wd[7:0];
      endcase
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] rdata; logic err; int cyc; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int n_cmp = 0;
  int n_bad = 0;

  // Monitor: every response is checked against the oldest expectation.
  always @(negedge clk) begin
    if (rsp_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rsp_unexpected: got rdata=%h err=%b at cycle %0d, required no response",
                 rsp_rdata, rsp_err, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (rsp_rdata !== mon_e.rdata || rsp_err !== mon_e.err || cyc != mon_e.cyc) begin
          n_bad++;
          $display("FAIL rsp: got rdata=%h err=%b cycle=%0d, required rdata=%h err=%b cycle=%0d",
                   rsp_rdata, rsp_err, cyc, mon_e.rdata, mon_e.err, mon_e.cyc);
        end else begin
          $display("rsp ok: rdata=%h err=%b cycle=%0d", rsp_rdata, rsp_err, cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  task automatic chk_log(input int idx, input logic [1:0] we, input logic [31:0] a,
                         input logic [31:0] wd);
    n_cmp++;
    if (idx >= wlog.size()) begin
      n_bad++;
      $display("FAIL wlog[%0d]: got no write, required we=%b a=%h wd=%h", idx, we, a, wd);
    end else if (wlog[idx].we !== we || wlog[idx].a !== a || wlog[idx].wd !== wd) begin
      n_bad++;
      $display("FAIL wlog[%0d]: got we=%b a=%h wd=%h required we=%b a=%h wd=%h", idx,
               wlog[idx].we, wlog[idx].a, wlog[idx].wd, we, a, wd);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit ref_aligned(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'b00) || (size == 2'b01 && addr[0] == 1'b0) ||
           (size == 2'b10 && addr[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns,
                                           input logic [31:0] addr);
    logic [31:0] v = 32'd0;
    logic [7:0]  idx;
    for (int i = 0; i < nbytes(size); i++) begin
      idx = 8'(addr + 32'(i));
      v[8*i +: 8] = ref_mem[idx];
    end
    if (!uns && size == 2'b00 && v[7])  v[31:8]  = 24'hFFFFFF;
    if (!uns && size == 2'b01 && v[15]) v[31:16] = 16'hFFFF;
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input int count);
    logic [7:0] idx;
    for (int i = 0; i < count && i < nbytes(size); i++) begin
      idx = 8'(addr + 32'(i));
      ref_mem[idx] = wdata[8*i +: 8];
    end
  endtask

  task automatic scramble();
    req_we       = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
  endtask

  // Issue one request; the expectation is the fixed value when given, else the model.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input bit fixed, input logic [31:0] fixed_val);
    exp_t e;
    int   n = 0;
    bit   al;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    while (!req_ready) begin
      @(negedge clk);
      n++;
      if (n > 40) begin
        n_cmp++; n_bad++;
        $display("FAIL req_ready_timeout: got ready=0 for %0d cycles, required 1", n);
        req_valid = 1'b0;
        return;
      end
    end
    al = ref_aligned(size, addr);
    e.err = 1'b0;
    e.rdata = 32'd0;
    if (size == 2'b11) begin
      e.err = 1'b1;
      e.cyc = cyc + 1;
    end else if (we) begin
      ref_store(size, addr, wdata, 4);
      e.cyc = cyc + (al ? 2 : 1 + nbytes(size));
    end else begin
      e.rdata = fixed ? fixed_val : ref_load(size, uns, addr);
      e.cyc = cyc + (al ? 2 : 3);
    end
    exp_q.push_back(e);
    $display("req: we=%b size=%b uns=%b addr=%h wdata=%h", we, size, uns, addr, wdata);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    scramble();
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && req_ready) done = 1'b1;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: got %0d pending responses, required 0", exp_q.size());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish by time limit, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int w = 0; w < 64; w++) begin
      init_val[w] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*w+b] = init_val[w][8*b +: 8];
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_dmem_we", {30'd0, dmem_we}, 32'd0);
    chk("rst_dmem_a", dmem_a, 32'd0);
    chk("rst_dmem_wd", dmem_wd, 32'd0);
    resetn = 1'b1;
    #1;
    chk("rst_release_ready", {31'd0, req_ready}, 32'd1);

    // Aligned word store then sub-word loads
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0);
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'd0, 1'b1, 32'hFFFFFFDE);
    do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'd0, 1'b1, 32'h0000DEAD);

    // Aligned half and byte stores into a cleared word
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'd0, 1'b0, 32'd0);
    wait_idle();
    wlog.delete();
    do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h00001234, 1'b0, 32'd0);
    wait_idle();
    chk_log(0, 2'b10, 32'h22, 32'h00001234);
    wlog.delete();
    do_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AB, 1'b0, 32'd0);
    wait_idle();
    chk_log(0, 2'b11, 32'h21, 32'h000000AB);
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 1'b1, 32'h1234AB00);

    // Misaligned word store becomes four byte writes
    wait_idle();
    wlog.delete();
    do_req(1'b1, 2'b10, 1'b0, 32'h05, 32'h11223344, 1'b0, 32'd0);
    wait_idle();
    chk("mis_store_nwrites", 32'(wlog.size()), 32'd4);
    chk_log(0, 2'b11, 32'h05, 32'h44);
    chk_log(1, 2'b11, 32'h06, 32'h33);
    chk_log(2, 2'b11, 32'h07, 32'h22);
    chk_log(3, 2'b11, 32'h08, 32'h11);
    do_req(1'b0, 2'b10, 1'b0, 32'h05, 32'd0, 1'b1, 32'h11223344);

    // Misaligned signed half load across a word boundary
    do_req(1'b1, 2'b10, 1'b0, 32'h04, 32'h80000000, 1'b0, 32'd0);
    do_req(1'b1, 2'b10, 1'b0, 32'h08, 32'h000000FF, 1'b0, 32'd0);
    do_req(1'b0, 2'b01, 1'b0, 32'h07, 32'd0, 1'b1, 32'hFFFFFF80);

    // Illegal size: error response, no memory write
    wait_idle();
    wlog.delete();
    do_req(1'b0, 2'b11, 1'b0, 32'h30, 32'hFFFFFFFF, 1'b0, 32'd0);
    do_req(1'b1, 2'b11, 1'b0, 32'h31, 32'hFFFFFFFF, 1'b0, 32'd0);
    wait_idle();
    chk("err_nwrites", 32'(wlog.size()), 32'd0);

    // Address wrap on the second word of a misaligned load
    do_req(1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'd0, 1'b0, 32'd0);
    do_req(1'b0, 2'b01, 1'b1, 32'hFFFFFFFF, 32'd0, 1'b0, 32'd0);

    // Reset during byte 2 of a misaligned word store
    wait_idle();
    wlog.delete();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h45; req_wdata = 32'hA1B2C3D4;
    k = cyc;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    scramble();
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("rst_mid_dmem_we", {30'd0, dmem_we}, 32'd0);
    chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rst_mid_ready_after", {31'd0, req_ready}, 32'd1);
    chk("rst_mid_nwrites", 32'(wlog.size()), 32'd2);
    chk_log(0, 2'b11, 32'h45, 32'hD4);
    chk_log(1, 2'b11, 32'h46, 32'hC3);
    ref_store(2'b10, 32'h45, 32'hA1B2C3D4, 2);
    $display("reset-abort store issued at cycle %0d", k);
    do_req(1'b0, 2'b10, 1'b0, 32'h44, 32'd0, 1'b0, 32'd0);
    do_req(1'b0, 2'b10, 1'b0, 32'h48, 32'd0, 1'b0, 32'd0);

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      int          r;
      r  = $urandom_range(0, 15);
      sz = (r == 0) ? 2'b11 : 2'(r % 3);
      a  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom, 1'b0, 32'd0);
    end

    wait_idle();
    repeat (2) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    for (int w = 0; w < 64; w++)
      chk($sformatf("mem[%0d]", w), mem[w],
          {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
